mul16_seq: RTL and testbench

//  Sequential 16x16 unsigned shift-and-add multiplier; downstream consumer of add16.

---
 rtl/mul16_seq_pkg.sv | 17 +
 rtl/mul16_seq_add16.sv | 18 +
 rtl/mul16_seq.sv | 102 ++++++++++
 tb/tb_mul16_seq.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mul16_seq_pkg.sv
// Shared definitions for the sequential 16x16 multiplier: operand width,
// step-counter width and the FSM state encoding.
package mul16_seq_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;

  // Counter value during the final shift-and-add step.
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul16_seq_add16.sv
// 16-bit ripple adder with carry in/out; the single adder the multiplier
// uses for every partial-product accumulation.
import mul16_seq_pkg::*;

module add16 (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  // Full-width sum; the extra top bit becomes the carry out.
  always_comb begin
    {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
  end

endmodule

// File: rtl/mul16_seq.sv
// Sequential 16x16 unsigned shift-and-add multiplier. One partial product is
// added per cycle through add16 and the 33-bit {Cout,Sum,q} is shifted right
// back into the accumulator/multiplier registers. After 16 steps the product
// is latched into P and a one-cycle done pulse is raised.
import mul16_seq_pkg::*;

module mul16_seq (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_q;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_p;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;

  // Partial product: multiplicand when the current multiplier LSB is set.
  always_comb begin
    w_addend = r_q[0] ? r_mcand : '0;
  end

  add16 u_add16 (
    .i_a    (r_acc),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // State register; reset abandons any multiply in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: start only matters in IDLE, DONE always lasts one cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (start) w_next_state = S_RUN;
      S_RUN:  if (r_cnt == LAST_STEP) w_next_state = S_DONE;
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Status outputs decoded purely from the registered state.
  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  // Datapath: operand capture, shift-and-add step, product latch on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_p     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand <= A;
            r_q     <= B;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_acc <= {w_cout, w_sum[WIDTH-1:1]};
          r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_STEP) begin
            r_p <= {w_cout, w_sum, r_q[WIDTH-1:1]};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign P = r_p;

endmodule

// File: tb/tb_mul16_seq.sv
// Directed testbench for mul16_seq: reset state, exact 16-step latency,
// carry retention, zero operands, mid-run reset, held start with operand
// changes, and a run of back-to-back products against A*B.
module tb_mul16_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [31:0] P;

  int nAssert = 0;
  int nFail   = 0;
  logic [31:0] lastP = 32'h0;

  mul16_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a runaway simulation.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the request inputs.
  task automatic applyStimulus(input logic s, input logic [15:0] a, input logic [15:0] b);
    start = s;
    A     = a;
    B     = b;
  endtask

  // One comparison: counts it and reports tag/observed/expected on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nAssert++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Full multiply from IDLE: accept, 15 quiet steps, done on the 16th, back to IDLE.
  task automatic runMul(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [31:0] expP);
    applyStimulus(1'b1, a, b);
    tick();
    applyStimulus(1'b0, ~a, ~b);
    checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd1);
    for (int i = 1; i <= 15; i++) begin
      tick();
      checkOutput({tag, "_doneLow"}, {31'b0, done}, 32'd0);
      checkOutput({tag, "_pHeld"}, P, lastP);
    end
    tick();
    checkOutput({tag, "_done"}, {31'b0, done}, 32'd1);
    checkOutput({tag, "_P"}, P, expP);
    lastP = expP;
    tick();
    checkOutput({tag, "_donePulse"}, {31'b0, done}, 32'd0);
    checkOutput({tag, "_idle"}, {31'b0, busy}, 32'd0);
    checkOutput({tag, "_pKept"}, P, expP);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;

    rst = 1'b1;
    applyStimulus(1'b0, 16'h0, 16'h0);
    tick();
    tick();
    rst = 1'b0;
    checkOutput("resetBusy", {31'b0, busy}, 32'd0);
    checkOutput("resetDone", {31'b0, done}, 32'd0);
    checkOutput("resetP", P, 32'h0);

    runMul("t1", 16'd3, 16'd5, 32'h0000000F);
    runMul("t2", 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    runMul("t3a", 16'h1234, 16'h0000, 32'h0);
    runMul("t3b", 16'h0000, 16'hBEEF, 32'h0);
    runMul("t3c", 16'h0001, 16'hBEEF, 32'h0000BEEF);

    // Reset part-way through a multiply: no done pulse, everything cleared.
    runMul("t4pre", 16'd11, 16'd13, 32'd143);
    applyStimulus(1'b1, 16'd7, 16'd9);
    tick();
    applyStimulus(1'b0, 16'd0, 16'd0);
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t4rstBusy", {31'b0, busy}, 32'd0);
    checkOutput("t4rstDone", {31'b0, done}, 32'd0);
    checkOutput("t4rstP", P, 32'h0);
    lastP = 32'h0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("t4noDone", {31'b0, done}, 32'd0);
    end
    runMul("t4retry", 16'd7, 16'd9, 32'd63);

    // Held start with operands changed right after acceptance, then auto re-accept.
    applyStimulus(1'b1, 16'd2, 16'd3);
    tick();
    applyStimulus(1'b1, 16'd100, 16'd100);
    for (int i = 1; i <= 15; i++) begin
      tick();
      checkOutput("t5doneLow", {31'b0, done}, 32'd0);
    end
    tick();
    checkOutput("t5done", {31'b0, done}, 32'd1);
    checkOutput("t5P", P, 32'd6);
    tick();
    checkOutput("t5idle", {31'b0, busy}, 32'd0);
    checkOutput("t5pulse", {31'b0, done}, 32'd0);
    tick();
    checkOutput("t5reaccept", {31'b0, busy}, 32'd1);
    applyStimulus(1'b0, 16'd0, 16'd0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      checkOutput("t5bDoneLow", {31'b0, done}, 32'd0);
      checkOutput("t5bPHeld", P, 32'd6);
    end
    tick();
    checkOutput("t5bDone", {31'b0, done}, 32'd1);
    checkOutput("t5bP", P, 32'd10000);
    lastP = 32'd10000;
    tick();
    checkOutput("t5bPulse", {31'b0, done}, 32'd0);

    // Back-to-back products against the arithmetic reference.
    for (int n = 0; n < 200; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      runMul("t6", ra, rb, {16'h0, ra} * {16'h0, rb});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
